// File: rtl/mpmc10_rd_strip_collect.sv
// Collects one DDR read burst strip by strip and turns each accepted beat into an
// aligned cache write; signals completion with done or an idle timeout with err.
module mpmc10_rd_strip_collect #(
    parameter int WID   = 256,
    parameter int TOCNT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      num_strips,
    input  logic [31:0]     addr_base,
    input  logic [WID-1:0]  rd_data,
    input  logic            rd_valid,
    output logic [5:0]      strip_cnt,
    output logic            valid,
    output logic            cwr,
    output logic [31:0]     cwr_adr,
    output logic [WID-1:0]  cwr_dat,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int AL = (WID == 128) ? 4 : 5;
    localparam int TW = (TOCNT < 2) ? 1 : $clog2(TOCNT + 1);

    generate
        if (WID != 256 && WID != 128) begin : g_bad_wid
            $error("mpmc10_rd_strip_collect: WID must be 256 or 128");
        end
        if (TOCNT < 1) begin : g_bad_tocnt
            $error("mpmc10_rd_strip_collect: TOCNT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     base_reg, base_next;
    logic [5:0]      nstr_reg, nstr_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic [TW-1:0]   idle_reg, idle_next;
    logic            valid_reg, valid_next;
    logic            cwr_reg, cwr_next;
    logic [31:0]     adr_reg, adr_next;
    logic [WID-1:0]  dat_reg, dat_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        nstr_next  = nstr_reg;
        cnt_next   = cnt_reg;
        idle_next  = idle_reg;
        valid_next = 1'b0;
        cwr_next   = 1'b0;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A beat arriving together with start is not part of the burst.
                if (start) begin
                    base_next  = {addr_base[31:AL], {AL{1'b0}}};
                    nstr_next  = num_strips;
                    cnt_next   = 6'd0;
                    idle_next  = '0;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rd_valid) begin
                    cwr_next   = 1'b1;
                    valid_next = 1'b1;
                    dat_next   = rd_data;
                    adr_next   = base_reg + (32'(cnt_reg) << AL);
                    idle_next  = '0;
                    if (cnt_reg == nstr_reg) begin
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end else if (idle_reg == TW'(TOCNT - 1)) begin
                    err_next   = 1'b1;
                    cnt_next   = 6'd0;
                    idle_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    idle_next = idle_reg + TW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            base_reg  <= '0;
            nstr_reg  <= '0;
            cnt_reg   <= '0;
            idle_reg  <= '0;
            valid_reg <= 1'b0;
            cwr_reg   <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            nstr_reg  <= nstr_next;
            cnt_reg   <= cnt_next;
            idle_reg  <= idle_next;
            valid_reg <= valid_next;
            cwr_reg   <= cwr_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign strip_cnt = cnt_reg;
    assign valid     = valid_reg;
    assign cwr       = cwr_reg;
    assign cwr_adr   = adr_reg;
    assign cwr_dat   = dat_reg;
    assign busy      = (state_reg == ST_COLLECT);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mpmc10_rd_strip_collect.sv
// Bench for mpmc10_rd_strip_collect: a 256-bit and a 128-bit instance driven in
// parallel, checked every cycle against a burst-level model plus literal addresses.
module tb_mpmc10_rd_strip_collect;

    localparam int TOCNT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   num_strips;
    logic [31:0]  addr_base;
    logic [255:0] rd_data;
    logic         rd_valid;

    logic [5:0]   o_cnt[2];
    logic         o_valid[2], o_cwr[2], o_busy[2], o_done[2], o_err[2];
    logic [31:0]  o_adr[2];
    logic [255:0] o_dat0;
    logic [127:0] o_dat1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mpmc10_rd_strip_collect #(.WID(256), .TOCNT(TOCNT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_strips(num_strips),
        .addr_base(addr_base), .rd_data(rd_data), .rd_valid(rd_valid),
        .strip_cnt(o_cnt[0]), .valid(o_valid[0]), .cwr(o_cwr[0]),
        .cwr_adr(o_adr[0]), .cwr_dat(o_dat0), .busy(o_busy[0]),
        .done(o_done[0]), .err(o_err[0])
    );

    mpmc10_rd_strip_collect #(.WID(128), .TOCNT(TOCNT)) dut128 (
        .clk(clk), .rst(rst), .start(start), .num_strips(num_strips),
        .addr_base(addr_base), .rd_data(rd_data[127:0]), .rd_valid(rd_valid),
        .strip_cnt(o_cnt[1]), .valid(o_valid[1]), .cwr(o_cwr[1]),
        .cwr_adr(o_adr[1]), .cwr_dat(o_dat1), .busy(o_busy[1]),
        .done(o_done[1]), .err(o_err[1])
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Burst-level model: where the burst is, how many strips arrived, idle time.
    int           m_st[2];      // 0 idle, 1 collecting, 2 finishing
    logic [31:0]  m_base[2];
    int           m_n[2], m_got[2], m_idle[2];
    int           stride[2] = '{32, 16};
    logic         exp_cwr[2], exp_valid[2], exp_done[2], exp_err[2], exp_busy[2];
    logic [5:0]   exp_cnt[2];
    logic [31:0]  exp_adr[2];
    logic [255:0] exp_dat[2];
    bit           model_live = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_cwr[i] = 0; exp_valid[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
            if (rst) begin
                m_st[i] = 0; m_got[i] = 0; m_idle[i] = 0;
                exp_adr[i] = '0; exp_dat[i] = '0;
            end else if (m_st[i] == 0) begin
                if (start) begin
                    m_base[i] = addr_base & ~32'(stride[i] - 1);
                    m_n[i] = int'(num_strips); m_got[i] = 0; m_idle[i] = 0; m_st[i] = 1;
                end
            end else if (m_st[i] == 1) begin
                if (rd_valid) begin
                    exp_cwr[i] = 1; exp_valid[i] = 1; m_idle[i] = 0;
                    exp_adr[i] = m_base[i] + 32'(m_got[i] * stride[i]);
                    exp_dat[i] = (i == 0) ? rd_data : {128'b0, rd_data[127:0]};
                    if (m_got[i] == m_n[i]) begin exp_done[i] = 1; m_st[i] = 2; end
                    else m_got[i]++;
                end else begin
                    m_idle[i]++;
                    if (m_idle[i] == TOCNT) begin
                        exp_err[i] = 1; m_st[i] = 0; m_got[i] = 0; m_idle[i] = 0;
                    end
                end
            end else begin
                m_st[i] = 0;
            end
            exp_busy[i] = (m_st[i] == 1);
            exp_cnt[i]  = 6'(m_got[i]);
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("strip_cnt%0d", i), 256'(o_cnt[i]), 256'(exp_cnt[i]));
                chk($sformatf("valid%0d", i), 256'(o_valid[i]), 256'(exp_valid[i]));
                chk($sformatf("cwr%0d", i), 256'(o_cwr[i]), 256'(exp_cwr[i]));
                chk($sformatf("busy%0d", i), 256'(o_busy[i]), 256'(exp_busy[i]));
                chk($sformatf("done%0d", i), 256'(o_done[i]), 256'(exp_done[i]));
                chk($sformatf("err%0d", i), 256'(o_err[i]), 256'(exp_err[i]));
                if (exp_cwr[i]) begin
                    chk($sformatf("cwr_adr%0d", i), 256'(o_adr[i]), 256'(exp_adr[i]));
                    chk($sformatf("cwr_dat%0d", i), (i == 0) ? o_dat0 : {128'b0, o_dat1}, exp_dat[i]);
                end
            end
        end
    end

    // Transaction log for the literal checks.
    logic [31:0] adr_q0[$], adr_q1[$];
    int done_n[2], err_n[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (o_cwr[i] === 1'b1) begin
                if (i == 0) adr_q0.push_back(o_adr[0]); else adr_q1.push_back(o_adr[1]);
                $display("cwr inst%0d adr=%08h dat=%0h done=%0b", i, o_adr[i],
                         (i == 0) ? o_dat0 : {128'b0, o_dat1}, o_done[i]);
            end
            if (o_done[i] === 1'b1) done_n[i]++;
            if (o_err[i] === 1'b1) begin
                err_n[i]++;
                $display("err inst%0d timeout", i);
            end
        end
    end

    function automatic logic [31:0] logged(input int i, input int idx);
        if (i == 0) return (idx < adr_q0.size()) ? adr_q0[idx] : 32'hxxxxxxxx;
        return (idx < adr_q1.size()) ? adr_q1[idx] : 32'hxxxxxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        adr_q0.delete(); adr_q1.delete();
        done_n = '{0, 0}; err_n = '{0, 0};
    endtask

    task automatic do_start(input logic [31:0] a, input logic [5:0] n);
        start = 1'b1; addr_base = a; num_strips = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [255:0] d);
        rd_valid = 1'b1; rd_data = d;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic chk_adrs(input string name, input int i, input int n,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] exp_a[4];
        exp_a = '{a0, a1, a2, a3};
        chk({name, "_count"}, 256'((i == 0) ? adr_q0.size() : adr_q1.size()), 256'(n));
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_adr%0d_%0d", name, i, k), 256'(logged(i, k)), 256'(exp_a[k]));
    endtask

    logic [255:0] d;

    initial begin
        rst = 1'b1; start = 1'b0; num_strips = '0; addr_base = '0;
        rd_data = '0; rd_valid = 1'b0;
        clear_log();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_adr%0d", i), 256'(o_adr[i]), 256'h0);
            chk($sformatf("rst_busy%0d", i), 256'(o_busy[i]), 256'h0);
        end
        chk("rst_dat0", o_dat0, 256'h0);
        rst = 1'b0;
        tick();

        // 1: four back-to-back strips; inputs change after start
        clear_log();
        do_start(32'h0000_1234, 6'd3);
        addr_base = 32'hDEAD_BEEF; num_strips = 6'd9;
        for (int k = 0; k < 4; k++) beat({8{32'hA000_0000 + 32'(k)}});
        chk("t1_done_with_last0", 256'(o_done[0]), 256'h1);
        repeat (2) tick();
        chk_adrs("t1", 0, 4, 32'h1220, 32'h1240, 32'h1260, 32'h1280);
        chk_adrs("t1", 1, 4, 32'h1230, 32'h1240, 32'h1250, 32'h1260);
        chk("t1_done_n0", 256'(done_n[0]), 256'd1);

        // 2: single strip; beat coinciding with start is dropped
        clear_log();
        start = 1'b1; addr_base = 32'h40; num_strips = 6'd0;
        rd_valid = 1'b1; rd_data = {8{32'hBAD0_BAD0}};
        tick();
        start = 1'b0; rd_valid = 1'b0;
        d = {4{64'h0123_4567_89AB_CDEF}};
        beat(d);
        chk("t2_dat0", o_dat0, d);
        repeat (2) tick();
        chk_adrs("t2", 0, 1, 32'h40, 32'h0, 32'h0, 32'h0);
        chk_adrs("t2", 1, 1, 32'h40, 32'h0, 32'h0, 32'h0);
        chk("t2_cnt0", 256'(o_cnt[0]), 256'h0);
        chk("t2_done_n1", 256'(done_n[1]), 256'd1);

        // 3: extra beat after the last strip; start mid-burst ignored
        clear_log();
        do_start(32'h2000, 6'd1);
        beat({8{32'h3333_0001}});
        start = 1'b1; addr_base = 32'h9000;
        beat({8{32'h3333_0002}});
        start = 1'b0;
        beat({8{32'h3333_0003}});
        repeat (3) tick();
        chk_adrs("t3", 0, 2, 32'h2000, 32'h2020, 32'h0, 32'h0);
        chk_adrs("t3", 1, 2, 32'h2000, 32'h2010, 32'h0, 32'h0);
        chk("t3_err_n0", 256'(err_n[0]), 256'd0);

        // 4: timeout after one beat, then a fresh burst
        clear_log();
        do_start(32'h3000, 6'd2);
        beat({8{32'h4444_0001}});
        repeat (TOCNT + 4) tick();
        chk("t4_err_n0", 256'(err_n[0]), 256'd1);
        chk("t4_err_n1", 256'(err_n[1]), 256'd1);
        chk("t4_done_n0", 256'(done_n[0]), 256'd0);
        chk("t4_busy0", 256'(o_busy[0]), 256'h0);
        do_start(32'h3100, 6'd0);
        beat({8{32'h4444_0002}});
        repeat (2) tick();
        chk_adrs("t4", 0, 2, 32'h3000, 32'h3100, 32'h0, 32'h0);
        chk("t4_done_after0", 256'(done_n[0]), 256'd1);

        // 5: address wrap
        clear_log();
        do_start(32'hFFFF_FFE0, 6'd1);
        beat({8{32'h5555_0001}});
        beat({8{32'h5555_0002}});
        repeat (2) tick();
        chk_adrs("t5", 0, 2, 32'hFFFF_FFE0, 32'h0, 32'h0, 32'h0);
        chk_adrs("t5", 1, 2, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'h0, 32'h0);

        // 6: reset mid-burst, later beats ignored until a new start
        clear_log();
        do_start(32'h5000, 6'd3);
        beat({8{32'h6666_0001}});
        beat({8{32'h6666_0002}});
        rst = 1'b1;
        tick();
        chk("t6_adr0", 256'(o_adr[0]), 256'h0);
        chk("t6_dat1", 256'(o_dat1), 256'h0);
        chk("t6_cnt0", 256'(o_cnt[0]), 256'h0);
        chk("t6_busy1", 256'(o_busy[1]), 256'h0);
        rst = 1'b0;
        beat({8{32'h6666_0003}});
        beat({8{32'h6666_0004}});
        repeat (3) tick();
        chk_adrs("t6", 0, 2, 32'h5000, 32'h5020, 32'h0, 32'h0);
        chk("t6_done_n0", 256'(done_n[0]), 256'd0);
        chk("t6_err_n0", 256'(err_n[0]), 256'd0);
        do_start(32'h5000, 6'd0);
        beat({8{32'h6666_0005}});
        repeat (2) tick();
        chk_adrs("t6b", 1, 3, 32'h5000, 32'h5010, 32'h5000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
